// File: rtl/lcd2vga_pkg.sv
// Shared types and timing helpers for the LCD-to-VGA lock scaler.
// Optional colour-bar build is selected with LCD2VGA_TEST_PATTERN_EN.
package lcd2vga_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned DEF_COLOR_BITS  = 1;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_H_FP        = 16;
  localparam int unsigned DEF_H_SP        = 96;
  localparam int unsigned DEF_H_BP        = 48;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_V_FP        = 10;
  localparam int unsigned DEF_V_SP        = 2;
  localparam int unsigned DEF_V_BP        = 33;
  localparam int unsigned DEF_LOCK_OFFSET = 36203;
  localparam int unsigned DEF_PERIOD_TOL  = 4;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sp, input int unsigned bp);
    return active + fp + sp + bp;
  endfunction

  function automatic int unsigned frame_total(input int unsigned h_total, input int unsigned v_total);
    return h_total * v_total;
  endfunction

endpackage

// File: rtl/lcd2vga_lock_scaler_vga_timing_gen.sv
// Free-running VGA raster counters with realign and sync/DE decode.
// With LCD2VGA_TEST_PATTERN_EN it also decodes the colour-bar index.
module vga_timing_gen
  import lcd2vga_pkg::*;
#(
  parameter int unsigned P_H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned P_H_FP     = DEF_H_FP,
  parameter int unsigned P_H_SP     = DEF_H_SP,
  parameter int unsigned P_H_BP     = DEF_H_BP,
  parameter int unsigned P_V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned P_V_FP     = DEF_V_FP,
  parameter int unsigned P_V_SP     = DEF_V_SP,
  parameter int unsigned P_V_BP     = DEF_V_BP
) (
  input  logic       iw_clk,
  input  logic       reset,
  input  logic       realign,
  output logic       de_c,
  output logic       hsync_c,
  output logic       vsync_c
`ifdef LCD2VGA_TEST_PATTERN_EN
  ,
  output logic [2:0] bar_c
`endif
);

  localparam int unsigned H_TOTAL  = line_total(P_H_ACTIVE, P_H_FP, P_H_SP, P_H_BP);
  localparam int unsigned V_TOTAL  = line_total(P_V_ACTIVE, P_V_FP, P_V_SP, P_V_BP);
  localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_START = P_H_ACTIVE + P_H_FP;
  localparam int unsigned HS_END   = HS_START + P_H_SP - 1;
  localparam int unsigned VS_START = P_V_ACTIVE + P_V_FP;
  localparam int unsigned VS_END   = VS_START + P_V_SP - 1;

  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;

  // Realign overrides the natural wrap so the raster restarts at the origin.
  always_ff @(posedge iw_clk) begin
    if (reset || realign) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == HW'(H_TOTAL - 1)) begin
      hpos <= '0;
      vpos <= (vpos == VW'(V_TOTAL - 1)) ? '0 : vpos + VW'(1);
    end else begin
      hpos <= hpos + HW'(1);
    end
  end

  assign hsync_c = !((hpos >= HW'(HS_START)) && (hpos <= HW'(HS_END)));
  assign vsync_c = !((vpos >= VW'(VS_START)) && (vpos <= VW'(VS_END)));
  assign de_c    = (hpos < HW'(P_H_ACTIVE)) && (vpos < VW'(P_V_ACTIVE));

`ifdef LCD2VGA_TEST_PATTERN_EN
  assign bar_c = 3'((32'(hpos) * 32'd8) / 32'(P_H_ACTIVE));
`endif

endmodule

// File: rtl/lcd2vga_lock_scaler.sv
// LCD-to-VGA timing regenerator with frame-sync lock detection and video gating.
// Define LCD2VGA_TEST_PATTERN_EN to show colour bars while unlocked.
module lcd2vga_lock_scaler
  import lcd2vga_pkg::*;
#(
  parameter int unsigned P_COLOR_BITS  = DEF_COLOR_BITS,
  parameter int unsigned P_H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned P_H_FP        = DEF_H_FP,
  parameter int unsigned P_H_SP        = DEF_H_SP,
  parameter int unsigned P_H_BP        = DEF_H_BP,
  parameter int unsigned P_V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned P_V_FP        = DEF_V_FP,
  parameter int unsigned P_V_SP        = DEF_V_SP,
  parameter int unsigned P_V_BP        = DEF_V_BP,
  parameter int unsigned P_LOCK_OFFSET = DEF_LOCK_OFFSET,
  parameter int unsigned P_PERIOD_TOL  = DEF_PERIOD_TOL,
  parameter int unsigned P_LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic                      iw_clk,
  input  logic                      reset,
  input  logic                      iw_sync,
  input  logic [3*P_COLOR_BITS-1:0] iw_rgb,
  output logic [3*P_COLOR_BITS-1:0] ow_rgb,
  output logic                      ow_hsync,
  output logic                      ow_vsync,
  output logic                      ow_de,
  output logic                      ow_locked,
  output logic [1:0]                ow_state
);

  localparam int unsigned H_TOTAL = line_total(P_H_ACTIVE, P_H_FP, P_H_SP, P_H_BP);
  localparam int unsigned V_TOTAL = line_total(P_V_ACTIVE, P_V_FP, P_V_SP, P_V_BP);
  localparam int unsigned FRAME   = frame_total(H_TOTAL, V_TOTAL);
  localparam int unsigned RGB_W   = 3 * P_COLOR_BITS;
  localparam int unsigned GW      = (P_LOCK_FRAMES < 1) ? 1 : $clog2(P_LOCK_FRAMES + 1);
  localparam logic [32:0] FRAME_W    = 33'(FRAME);
  localparam logic [32:0] TOL_W      = 33'(P_PERIOD_TOL);
  localparam logic [31:0] TIMEOUT_W  = 32'(FRAME + P_PERIOD_TOL);
  localparam logic [31:0] REALIGN_AT = 32'(P_LOCK_OFFSET - 1);

  state_t            state;
  logic              locked;
  logic [GW-1:0]     good_cnt;
  logic              sync_d;
  logic [31:0]       since_sync;
  logic              sync_rise_c;
  logic              realign_c;
  logic              timeout_c;
  logic              period_ok_c;
  logic [32:0]       period_c;
  logic              de_c;
  logic              hsync_c;
  logic              vsync_c;
  logic [RGB_W-1:0]  rgb_c;
`ifdef LCD2VGA_TEST_PATTERN_EN
  logic [2:0]        bar_c;
`endif

  vga_timing_gen #(
    .P_H_ACTIVE (P_H_ACTIVE),
    .P_H_FP     (P_H_FP),
    .P_H_SP     (P_H_SP),
    .P_H_BP     (P_H_BP),
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_FP     (P_V_FP),
    .P_V_SP     (P_V_SP),
    .P_V_BP     (P_V_BP)
  ) u_timing (
    .iw_clk  (iw_clk),
    .reset   (reset),
    .realign (realign_c),
    .de_c    (de_c),
    .hsync_c (hsync_c),
    .vsync_c (vsync_c)
`ifdef LCD2VGA_TEST_PATTERN_EN
    ,
    .bar_c   (bar_c)
`endif
  );

  // A sync edge always takes priority over both realign and timeout.
  assign sync_rise_c = iw_sync & ~sync_d;
  assign realign_c   = !sync_rise_c && (state != SEARCH) && (since_sync == REALIGN_AT);
  assign timeout_c   = (state != SEARCH) && (since_sync > TIMEOUT_W);
  assign period_c    = {1'b0, since_sync} + 33'd1;
  assign period_ok_c = (period_c >= FRAME_W) ? ((period_c - FRAME_W) <= TOL_W)
                                             : ((FRAME_W - period_c) <= TOL_W);

  always_ff @(posedge iw_clk) begin
    if (reset) begin
      sync_d     <= 1'b0;
      since_sync <= '0;
    end else begin
      sync_d <= iw_sync;
      if (sync_rise_c) begin
        since_sync <= '0;
      end else if (since_sync != '1) begin
        since_sync <= since_sync + 32'd1;
      end
    end
  end

  // Lock FSM; the locked flag is updated alongside every state change.
  always_ff @(posedge iw_clk) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (sync_rise_c) begin
      unique case (state)
        SEARCH: begin
          state    <= ALIGN;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
        ALIGN: begin
          if (period_ok_c) begin
            good_cnt <= good_cnt + GW'(1);
            if ((32'(good_cnt) + 32'd1) >= 32'(P_LOCK_FRAMES)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!period_ok_c) begin
            state    <= ALIGN;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end else if (timeout_c) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
    end
  end

  always_comb begin
    rgb_c = '0;
    if (de_c) begin
      if (state == LOCKED) begin
        rgb_c = iw_rgb;
      end
`ifdef LCD2VGA_TEST_PATTERN_EN
      else begin
        rgb_c = {{P_COLOR_BITS{bar_c[2]}}, {P_COLOR_BITS{bar_c[1]}}, {P_COLOR_BITS{bar_c[0]}}};
      end
`endif
    end
  end

  always_ff @(posedge iw_clk) begin
    if (reset) begin
      ow_rgb   <= '0;
      ow_hsync <= 1'b1;
      ow_vsync <= 1'b1;
      ow_de    <= 1'b0;
    end else begin
      ow_rgb   <= rgb_c;
      ow_hsync <= hsync_c;
      ow_vsync <= vsync_c;
      ow_de    <= de_c;
    end
  end

  assign ow_locked = locked;
  assign ow_state  = state;

endmodule
